ddc_iq_packer: RTL and testbench
================================

Name: ddc_iq_packer

Overview:
- Downstream consumer of the DDC serial-to-parallel demux.
- Takes aligned 24-bit I/Q sample pairs and rounds/saturates each to 16 bits.
- Packs two pairs into one 64-bit word and buffers the words in a small first-word-fall-through (FWFT) FIFO.
- Presents the words to the PCIe DMA write path through a valid/ready handshake, with overflow and pairing-error status.

Parameters:
- IN_WIDTH, 24, input sample width (signed); must be > OUT_WIDTH.
- OUT_WIDTH, 16, packed sample width (signed); fixed so that 4*OUT_WIDTH = 64.
- FIFO_DEPTH, 8, number of output word slots; power of two, ≥ 2.
- CNT_WIDTH, 16, width of the overflow counter.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  synchronous reset, active-high.
- Enable  in  1  capture enable; low = ignore inputs.
- Data_In_I  in  IN_WIDTH  signed I sample.
- Data_In_I_Valid  in  1  I sample strobe.
- Data_In_Q  in  IN_WIDTH  signed Q sample.
- Data_In_Q_Valid  in  1  Q sample strobe.
- Word_Out  out  64  packed word {Q1,I1,Q0,I0}; pair 0 sits in bits [31:0].
- Word_Out_Valid  out  1  FIFO not empty.
- Word_Out_Ready  in  1  consumer accepts Word_Out.
- Fifo_Level  out  clog2(FIFO_DEPTH)+1  words held.
- Overflow_Cnt  out  CNT_WIDTH  words dropped because the FIFO was full; saturating.
- Pair_Err  out  1  sticky; set when exactly one of the I/Q valids is high.

Behaviour:
- Reset: all outputs 0; FIFO empty; pack state EMPTY; rounding register cleared. RST overrides every other input in the same cycle, and a partial pair or in-flight word is discarded.
- Pair acceptance: cycle where Enable=1 and both valids=1.
- Mismatch: Enable=1 with exactly one valid=1 → sample dropped, Pair_Err set. Pair_Err is cleared only by RST.
- Round/saturate stage (registered):
  - Add 2^(IN_WIDTH-OUT_WIDTH-1) in IN_WIDTH+1 bits.
  - Arithmetic shift right by IN_WIDTH-OUT_WIDTH.
  - If the result exceeds 2^(OUT_WIDTH-1)-1, clamp to 0x7FFF. Negative values cannot overflow.
- Pack state machine:
  - EMPTY: a rounded pair arriving is stored as pair 0 → HALF.
  - HALF: a rounded pair arriving forms the word → push request, → EMPTY.
  - A pair at most every cycle must be sustained with no bubbles.
- Latency: a pair accepted in cycle c completes a word → word written at end of c+1 → Word_Out_Valid=1 in cycle c+2 if the FIFO was empty.
- FIFO:
  - FWFT: Word_Out always shows the head entry. Pop on Word_Out_Valid & Word_Out_Ready.
  - Push while full with no pop → word dropped and Overflow_Cnt increments, holding at all-ones.
  - Push and pop in the same cycle while full → both succeed; level unchanged, no overflow.
  - Push and pop in the same cycle while empty → push only; the word becomes visible next cycle.
  - Read/write pointers wrap modulo FIFO_DEPTH. Fifo_Level is exact at all times.
- Enable:
  - Falling Enable (1→0) discards a HALF pair (state → EMPTY).
  - Words already pushed or in flight still drain. Enable has no effect on the output side.
- Word_Out is don't-care when Word_Out_Valid=0, but must hold stable while Valid=1 and Ready=0.

Decomposition:
- Shared DDC package holds:
  - the rounding/saturation function (round-half-up + clamp), reusable by other DDC stages;
  - constants PCIE_WORD_WIDTH=64 and DDC_SAMPLE_WIDTH=24.
- One sub-module: ddc_sync_fifo_fwft (parameterised width/depth, level output, full/empty).

Test Plan:
1. Rounding: I=0x123480, Q=0xFFFF7F → I0=0x1235, Q0=0xFFFF. After a second pair of zeros, Word_Out=0x0000_0000_FFFF_1235.
2. Saturation: I=0x7FFFFF, Q=0x800000 (×2 pairs) → Word_Out=0x8000_7FFF_8000_7FFF; Pair_Err=0.
3. Throughput/latency: 16 back-to-back pairs with Ready=1 → first Word_Out_Valid exactly 2 cycles after pair 2; 8 words in order; Overflow_Cnt=0.
4. Overflow: Ready=0, send 20 pairs (10 words) with FIFO_DEPTH=8 → Fifo_Level=8, Overflow_Cnt=2; then Ready=1 drains the first 8 words in order.
5. Full push+pop: FIFO full, Ready=1 in the same cycle a word completes → level stays 8, Overflow_Cnt unchanged.
6. Mismatch/Enable/reset:
   - I valid alone → Pair_Err=1, no word produced.
   - One pair, then Enable pulsed low, then two pairs → a single word containing only the last two pairs.
   - RST mid-stream → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/ddc_iq_packer_pkg.sv
// Shared DDC definitions: bus/sample widths, pack states and the round/saturate helper.
package ddc_iq_packer_pkg;
   localparam int PCIE_WORD_WIDTH  = 64;
   localparam int DDC_SAMPLE_WIDTH = 24;

   typedef enum logic {
      PACK_EMPTY = 1'b0,
      PACK_HALF  = 1'b1
   } pack_state_e;

   // Round half up, then clamp the positive side. in_w/out_w are constants at every call site.
   function automatic logic [31:0] ddc_round_sat(input logic signed [63:0] x,
                                                 input int in_w, input int out_w);
      logic signed [64:0] sum;
      logic signed [64:0] shifted;
      logic signed [64:0] max_pos;
      sum     = $signed({x[63], x}) + (65'sd1 <<< (in_w - out_w - 1));
      shifted = sum >>> (in_w - out_w);
      max_pos = (65'sd1 <<< (out_w - 1)) - 65'sd1;
      if (shifted > max_pos) shifted = max_pos;
      return 32'(shifted);
   endfunction
endpackage

// File: rtl/ddc_iq_packer_fifo.sv
// Small synchronous first-word-fall-through FIFO with exact level; a write when full only lands with a read.
module ddc_sync_fifo_fwft #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_wr, do_rd;

   always_comb begin
      empty    = (level_q == '0);
      full     = (level_q == (AW+1)'(DEPTH));
      do_rd    = rd_en & ~empty;
      do_wr    = wr_en & (~full | do_rd);
      wr_ptr_d = wr_ptr_q + AW'(do_wr);
      rd_ptr_d = rd_ptr_q + AW'(do_rd);
      level_d  = level_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      mem_d    = mem_q;
      if (do_wr) mem_d[wr_ptr_q] = wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         mem_q    <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign level   = level_q;
endmodule

// File: rtl/ddc_iq_packer.sv
// IQ packer: rounds I/Q pairs to 16 bits, packs two pairs per 64-bit word and queues words for the DMA path.
//   state      | meaning
//   PACK_EMPTY | no pair held; next rounded pair becomes pair 0
//   PACK_HALF  | pair 0 held; next rounded pair completes and pushes the word
module ddc_iq_packer
   import ddc_iq_packer_pkg::*;
#(
   parameter int IN_WIDTH   = DDC_SAMPLE_WIDTH,
   parameter int OUT_WIDTH  = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          Enable,
   input  logic [IN_WIDTH-1:0]           Data_In_I,
   input  logic                          Data_In_I_Valid,
   input  logic [IN_WIDTH-1:0]           Data_In_Q,
   input  logic                          Data_In_Q_Valid,
   output logic [PCIE_WORD_WIDTH-1:0]    Word_Out,
   output logic                          Word_Out_Valid,
   input  logic                          Word_Out_Ready,
   output logic [$clog2(FIFO_DEPTH):0]   Fifo_Level,
   output logic [CNT_WIDTH-1:0]          Overflow_Cnt,
   output logic                          Pair_Err
);
   pack_state_e              state_q, state_d;
   logic [OUT_WIDTH-1:0]     rnd_i_q, rnd_i_d, rnd_q_q, rnd_q_d;
   logic                     rnd_vld_q, rnd_vld_d;
   logic [2*OUT_WIDTH-1:0]   pair0_q, pair0_d;
   logic                     en_q, en_d;
   logic                     pair_err_q, pair_err_d;
   logic [CNT_WIDTH-1:0]     ovf_cnt_q, ovf_cnt_d;
   logic                     accept, en_fall, push, pop, overflow;
   logic                     fifo_full, fifo_empty;
   logic [PCIE_WORD_WIDTH-1:0] push_word;

   always_comb begin
      accept    = Enable & Data_In_I_Valid & Data_In_Q_Valid;
      en_fall   = en_q & ~Enable;
      push      = rnd_vld_q & (state_q == PACK_HALF);
      pop       = ~fifo_empty & Word_Out_Ready;
      overflow  = push & fifo_full & ~pop;
      push_word = {rnd_q_q, rnd_i_q, pair0_q};

      rnd_vld_d = accept;
      rnd_i_d   = rnd_i_q;
      rnd_q_d   = rnd_q_q;
      if (accept) begin
         rnd_i_d = OUT_WIDTH'(ddc_round_sat(64'($signed(Data_In_I)), IN_WIDTH, OUT_WIDTH));
         rnd_q_d = OUT_WIDTH'(ddc_round_sat(64'($signed(Data_In_Q)), IN_WIDTH, OUT_WIDTH));
      end

      en_d       = Enable;
      pair_err_d = pair_err_q | (Enable & (Data_In_I_Valid ^ Data_In_Q_Valid));
      ovf_cnt_d  = (overflow && (ovf_cnt_q != '1)) ? ovf_cnt_q + CNT_WIDTH'(1) : ovf_cnt_q;

      // A completing word still pushes on an Enable drop; only a lone half pair is discarded.
      state_d = state_q;
      pair0_d = pair0_q;
      if (push) begin
         state_d = PACK_EMPTY;
      end else if (rnd_vld_q && !en_fall) begin
         state_d = PACK_HALF;
         pair0_d = {rnd_q_q, rnd_i_q};
      end else if (en_fall) begin
         state_d = PACK_EMPTY;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= PACK_EMPTY;
         rnd_i_q    <= '0;
         rnd_q_q    <= '0;
         rnd_vld_q  <= 1'b0;
         pair0_q    <= '0;
         en_q       <= 1'b0;
         pair_err_q <= 1'b0;
         ovf_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         rnd_i_q    <= rnd_i_d;
         rnd_q_q    <= rnd_q_d;
         rnd_vld_q  <= rnd_vld_d;
         pair0_q    <= pair0_d;
         en_q       <= en_d;
         pair_err_q <= pair_err_d;
         ovf_cnt_q  <= ovf_cnt_d;
      end
   end

   ddc_sync_fifo_fwft #(
      .WIDTH (PCIE_WORD_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .wr_en   (push),
      .wr_data (push_word),
      .rd_en   (pop),
      .rd_data (Word_Out),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (Fifo_Level)
   );

   assign Word_Out_Valid = ~fifo_empty;
   assign Overflow_Cnt   = ovf_cnt_q;
   assign Pair_Err       = pair_err_q;
endmodule

// File: tb/tb_ddc_iq_packer.sv
// Directed bench for ddc_iq_packer: rounding vectors from a table, then latency, overflow and control sequences.
module tb_ddc_iq_packer;
   logic        CLK = 1'b0;
   logic        RST, Enable, iv, qv, Word_Out_Ready;
   logic [23:0] di, dq;
   logic [63:0] Word_Out;
   logic        Word_Out_Valid;
   logic [3:0]  Fifo_Level;
   logic [15:0] Overflow_Cnt;
   logic        Pair_Err;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 CLK = ~CLK;

   ddc_iq_packer dut (
      .CLK             (CLK),
      .RST             (RST),
      .Enable          (Enable),
      .Data_In_I       (di),
      .Data_In_I_Valid (iv),
      .Data_In_Q       (dq),
      .Data_In_Q_Valid (qv),
      .Word_Out        (Word_Out),
      .Word_Out_Valid  (Word_Out_Valid),
      .Word_Out_Ready  (Word_Out_Ready),
      .Fifo_Level      (Fifo_Level),
      .Overflow_Cnt    (Overflow_Cnt),
      .Pair_Err        (Pair_Err)
   );

   typedef struct {
      logic [23:0] i0, q0, i1, q1;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs[5];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic en, input logic vi, input logic [23:0] i,
                        input logic vq, input logic [23:0] q);
      Enable = en; iv = vi; di = i; qv = vq; dq = q;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Raw {v,8'h00} rounds exactly to v, so packed words follow directly from the pair index.
   function automatic logic [23:0] raw(input logic [15:0] v);
      return {v, 8'h00};
   endfunction
   function automatic logic [15:0] samp_i(input int k);
      return 16'h1000 + 16'(k);
   endfunction
   function automatic logic [15:0] samp_q(input int k);
      return 16'hF000 + 16'(k);
   endfunction
   function automatic logic [63:0] mkword(input int a, input int b);
      return {samp_q(b), samp_i(b), samp_q(a), samp_i(a)};
   endfunction

   task automatic send(input int k);
      drive(1'b1, 1'b1, raw(samp_i(k)), 1'b1, raw(samp_q(k)));
      tick();
   endtask
   task automatic idle();
      drive(1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
      tick();
   endtask
   task automatic do_reset();
      RST = 1'b1;
      Word_Out_Ready = 1'b0;
      drive(1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
      tick();
      tick();
      RST = 1'b0;
   endtask
   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 64'(Word_Out_Valid), 64'd0);
      check({tag, "_word"},  Word_Out,            64'd0);
      check({tag, "_level"}, 64'(Fifo_Level),     64'd0);
      check({tag, "_ovf"},   64'(Overflow_Cnt),   64'd0);
      check({tag, "_perr"},  64'(Pair_Err),       64'd0);
   endtask

   initial begin
      int first;
      int nw;

      vecs[0] = '{24'h123480, 24'hFFFF7F, 24'h000000, 24'h000000, 64'h0000_0000_FFFF_1235};
      vecs[1] = '{24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 64'h8000_7FFF_8000_7FFF};
      vecs[2] = '{24'h000080, 24'h00007F, 24'hFFFF80, 24'hFFFF7F, 64'hFFFF_0000_0000_0001};
      vecs[3] = '{24'h7FFF7F, 24'h7FFF80, 24'h123456, 24'hEDCBA9, 64'hEDCC_1234_7FFF_7FFF};
      vecs[4] = '{24'hFFFFFF, 24'h800080, 24'h400000, 24'hC00000, 64'hC000_4000_8001_0000};

      do_reset();
      check_all_zero("reset");

      // Rounding / saturation table: one word per vector, popped before the next.
      foreach (vecs[v]) begin
         drive(1'b1, 1'b1, vecs[v].i0, 1'b1, vecs[v].q0); tick();
         drive(1'b1, 1'b1, vecs[v].i1, 1'b1, vecs[v].q1); tick();
         idle();
         check("tbl_valid", 64'(Word_Out_Valid), 64'd1);
         check("tbl_word",  Word_Out,            vecs[v].exp);
         check("tbl_perr",  64'(Pair_Err),       64'd0);
         Word_Out_Ready = 1'b1;
         tick();
         Word_Out_Ready = 1'b0;
         check("tbl_popped", 64'(Word_Out_Valid), 64'd0);
      end

      // Back-to-back pairs with Ready held high.
      do_reset();
      Word_Out_Ready = 1'b1;
      first = -1;
      nw = 0;
      for (int t = 1; t <= 30; t++) begin
         if (t <= 16) drive(1'b1, 1'b1, raw(samp_i(t-1)), 1'b1, raw(samp_q(t-1)));
         else         drive(1'b1, 1'b0, 24'h0, 1'b0, 24'h0);
         tick();
         if (Word_Out_Valid) begin
            if (first < 0) first = t;
            if (nw < 8) check("thru_word", Word_Out, mkword(2*nw, 2*nw+1));
            nw++;
         end
      end
      check("thru_first_valid", 64'(first), 64'd3);
      check("thru_word_count",  64'(nw),    64'd8);
      check("thru_ovf",         64'(Overflow_Cnt), 64'd0);

      // Overflow: 10 words into 8 slots with Ready low.
      do_reset();
      for (int k = 0; k < 20; k++) send(k);
      idle(); idle(); idle();
      check("ovf_level", 64'(Fifo_Level),   64'd8);
      check("ovf_cnt",   64'(Overflow_Cnt), 64'd2);
      Word_Out_Ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         check("ovf_drain", Word_Out, mkword(2*j, 2*j+1));
         idle();
      end
      Word_Out_Ready = 1'b0;
      check("ovf_empty", 64'(Word_Out_Valid), 64'd0);
      check("ovf_level0", 64'(Fifo_Level),   64'd0);

      // Full FIFO: push and pop land in the same cycle.
      do_reset();
      for (int k = 0; k < 17; k++) send(k);
      idle(); idle();
      check("full_level", 64'(Fifo_Level), 64'd8);
      send(17);
      Word_Out_Ready = 1'b1;
      idle();
      Word_Out_Ready = 1'b0;
      check("pp_level", 64'(Fifo_Level),   64'd8);
      check("pp_ovf",   64'(Overflow_Cnt), 64'd0);
      Word_Out_Ready = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         check("pp_drain", Word_Out, mkword(2*j, 2*j+1));
         idle();
      end
      Word_Out_Ready = 1'b0;
      check("pp_empty", 64'(Word_Out_Valid), 64'd0);

      // Lone I valid: sticky error, no word.
      do_reset();
      drive(1'b1, 1'b1, raw(samp_i(0)), 1'b0, 24'h0); tick();
      idle(); idle(); idle();
      check("mis_perr",  64'(Pair_Err),       64'd1);
      check("mis_valid", 64'(Word_Out_Valid), 64'd0);
      drive(1'b1, 1'b1, raw(samp_i(1)), 1'b1, raw(samp_q(1))); tick();
      idle();
      check("mis_sticky", 64'(Pair_Err), 64'd1);

      // Enable dropped after one pair: that pair and the ignored one are discarded.
      do_reset();
      send(0);
      drive(1'b0, 1'b1, raw(samp_i(5)), 1'b1, raw(samp_q(5))); tick();
      send(1);
      send(2);
      idle();
      check("en_valid", 64'(Word_Out_Valid), 64'd1);
      check("en_word",  Word_Out,            mkword(1, 2));
      idle(); idle(); idle();
      check("en_level", 64'(Fifo_Level), 64'd1);
      check("en_perr",  64'(Pair_Err),   64'd0);

      // Reset mid-stream with a word queued and a half pair held.
      send(3);
      RST = 1'b1;
      drive(1'b1, 1'b1, raw(samp_i(4)), 1'b1, raw(samp_q(4)));
      tick();
      RST = 1'b0;
      check_all_zero("rst_mid");
      send(6);
      send(7);
      idle(); idle();
      check("post_rst_level", 64'(Fifo_Level), 64'd1);
      check("post_rst_word",  Word_Out,        mkword(6, 7));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
